// File: rtl/spi_frame_sched.sv
// spi_frame_sched
// Walks a frame of pixels out of frame-buffer BRAM and hands them one at a
// time to the SPI pixel sender. For each pixel it fetches from BRAM, pulses
// the sender's trigger with data and position, waits for the sender's
// transaction to complete, and then inserts an idle gap before the next fetch.
// A sender that never goes busy raises a sticky error and abandons the frame.
module spi_frame_sched #(
  parameter int H_PIXELS     = 640,
  parameter int V_PIXELS     = 360,
  parameter int DATA_WIDTH   = 8,
  parameter int BRAM_LATENCY = 2,
  parameter int GAP_CYCLES   = 4,
  parameter int ACK_TIMEOUT  = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  frame_start_in,
  input  logic                  pause_in,
  output logic [17:0]           bram_addr_out,
  input  logic [DATA_WIDTH-1:0] bram_data_in,
  input  logic                  spi_busy_in,
  output logic                  spi_trigger_out,
  output logic [DATA_WIDTH-1:0] spi_data_out,
  output logic [9:0]            hcount_out,
  output logic [8:0]            vcount_out,
  output logic                  frame_busy_out,
  output logic                  frame_done_out,
  output logic                  error_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_TRIG,
    S_WAIT_ACK,
    S_WAIT_IDLE,
    S_GAP,
    S_DONE
  } state_t;

  // Terminal values for the shared cycle counter in each timed state.
  localparam logic [15:0] FETCH_LAST = 16'(BRAM_LATENCY - 1);
  localparam logic [15:0] ACK_LAST   = 16'(ACK_TIMEOUT - 1);
  localparam logic [16:0] GAP_LEN    = 17'(GAP_CYCLES);

  state_t                r_state;
  logic [15:0]           r_cnt;
  logic [17:0]           r_addr;
  logic [9:0]            r_hcount;
  logic [8:0]            r_vcount;
  logic                  r_trigger;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_frame_busy;
  logic                  r_done;
  logic                  r_error;

  logic w_line_end;
  logic w_last_pixel;
  logic w_fetch_done;
  logic w_ack_expired;
  logic w_gap_reached;
  logic w_gap_done;
  logic w_skip_gap;

  // Position and timing decodes used by the sequencer.
  assign w_line_end    = (r_hcount == 10'(H_PIXELS - 1));
  assign w_last_pixel  = w_line_end && (r_vcount == 9'(V_PIXELS - 1));
  assign w_fetch_done  = (r_cnt == FETCH_LAST);
  assign w_ack_expired = (r_cnt == ACK_LAST);
  // The gap is complete once the counter covers GAP_CYCLES cycles; pause
  // holds the sequencer here until it is released.
  assign w_gap_reached = (({1'b0, r_cnt} + 17'd1) >= GAP_LEN);
  assign w_gap_done    = w_gap_reached && !pause_in;
  // With no gap configured the GAP state is only visited to honour pause.
  assign w_skip_gap    = (GAP_CYCLES == 0) && !pause_in;

  // Frame sequencer: state, position counters and all registered outputs.
  // NOTE: every register here uses non-blocking assignment so each branch
  // reads the values from before the clock edge, regardless of order.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_addr       <= '0;
      r_hcount     <= '0;
      r_vcount     <= '0;
      r_trigger    <= 1'b0;
      r_data       <= '0;
      r_frame_busy <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      // Trigger and done are single-cycle pulses unless re-asserted below.
      r_trigger <= 1'b0;
      r_done    <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (frame_start_in) begin
            r_addr       <= '0;
            r_hcount     <= '0;
            r_vcount     <= '0;
            r_cnt        <= '0;
            r_frame_busy <= 1'b1;
            r_state      <= S_FETCH;
          end
        end

        // Address is already registered; wait out the BRAM read latency.
        S_FETCH: begin
          if (w_fetch_done) begin
            r_state <= S_TRIG;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        // BRAM data is valid now: capture it and pulse the sender.
        S_TRIG: begin
          r_data    <= bram_data_in;
          r_trigger <= 1'b1;
          r_cnt     <= '0;
          r_state   <= S_WAIT_ACK;
        end

        // Sender must show busy within ACK_TIMEOUT cycles of the trigger.
        S_WAIT_ACK: begin
          if (spi_busy_in) begin
            r_state <= S_WAIT_IDLE;
          end else if (w_ack_expired) begin
            r_error      <= 1'b1;
            r_frame_busy <= 1'b0;
            r_state      <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        // Sender's chip select has risen: move on to the next pixel.
        S_WAIT_IDLE: begin
          if (!spi_busy_in) begin
            r_cnt <= '0;
            if (w_last_pixel) begin
              // Position is left on the final pixel; DONE clears it so the
              // address never steps past the end of the frame.
              r_state <= S_DONE;
            end else begin
              r_addr <= r_addr + 18'd1;
              if (w_line_end) begin
                r_hcount <= '0;
                r_vcount <= r_vcount + 9'd1;
              end else begin
                r_hcount <= r_hcount + 10'd1;
              end
              r_state <= w_skip_gap ? S_FETCH : S_GAP;
            end
          end
        end

        // Idle gap between transactions, stretched while pause is held.
        S_GAP: begin
          if (w_gap_done) begin
            r_cnt   <= '0;
            r_state <= S_FETCH;
          end else if (!w_gap_reached) begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        S_DONE: begin
          r_done       <= 1'b1;
          r_frame_busy <= 1'b0;
          r_addr       <= '0;
          r_hcount     <= '0;
          r_vcount     <= '0;
          r_state      <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bram_addr_out   = r_addr;
  assign spi_trigger_out = r_trigger;
  assign spi_data_out    = r_data;
  assign hcount_out      = r_hcount;
  assign vcount_out      = r_vcount;
  assign frame_busy_out  = r_frame_busy;
  assign frame_done_out  = r_done;
  assign error_out       = r_error;

endmodule

// File: tb/tb_spi_frame_sched.sv
// tb_spi_frame_sched
// Drives the scheduler with a BRAM model and an SPI sender model using
// randomised acknowledge delays, busy lengths and pause activity. A
// transaction-level reference derives, from the inputs sampled at each clock
// edge, when each trigger, done pulse and error must appear and what pixel
// each trigger must carry. A reduced frame size keeps the run short.
module tb_spi_frame_sched;

  localparam int H    = 8;
  localparam int V    = 4;
  localparam int LAT  = 2;
  localparam int GAP  = 4;
  localparam int ACK  = 16;
  localparam int NPIX = H * V;

  logic        clk = 1'b0;
  logic        rst_in = 1'b0;
  logic        frame_start_in = 1'b0;
  logic        pause_in = 1'b0;
  logic [17:0] bram_addr_out;
  logic [7:0]  bram_data_in = 8'h00;
  logic        spi_busy_in = 1'b0;
  logic        spi_trigger_out;
  logic [7:0]  spi_data_out;
  logic [9:0]  hcount_out;
  logic [8:0]  vcount_out;
  logic        frame_busy_out;
  logic        frame_done_out;
  logic        error_out;

  spi_frame_sched #(
    .H_PIXELS    (H),
    .V_PIXELS    (V),
    .DATA_WIDTH  (8),
    .BRAM_LATENCY(LAT),
    .GAP_CYCLES  (GAP),
    .ACK_TIMEOUT (ACK)
  ) dut (
    .clk_in         (clk),
    .rst_in         (rst_in),
    .frame_start_in (frame_start_in),
    .pause_in       (pause_in),
    .bram_addr_out  (bram_addr_out),
    .bram_data_in   (bram_data_in),
    .spi_busy_in    (spi_busy_in),
    .spi_trigger_out(spi_trigger_out),
    .spi_data_out   (spi_data_out),
    .hcount_out     (hcount_out),
    .vcount_out     (vcount_out),
    .frame_busy_out (frame_busy_out),
    .frame_done_out (frame_done_out),
    .error_out      (error_out)
  );

  initial forever #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic s_rst, s_start, s_pause;
  initial forever begin
    @(posedge clk);
    cyc++;
    s_rst   = rst_in;
    s_start = frame_start_in;
    s_pause = pause_in;
  end

  logic [7:0] mem [NPIX];
  int         hist [LAT+1];

  // Reference: what the scheduler should be doing between clock edges.
  typedef enum int {M_IDLE, M_PEND, M_XFER, M_NOACK, M_GAP, M_DONE} mph_t;
  mph_t mph = M_IDLE;
  int   idx = 0;
  int   trig_at = -1, fall_at = -1, err_at = -1, done_at = -1, gap_from = -1;
  int   busy_on = -1, busy_off = -1;
  bit   err_exp = 1'b0;
  bit   bfm_noack = 1'b0;
  int   trig_count = 0;
  int   frames_done = 0;
  int   dut_done_cnt = 0;
  bit   err_seen = 1'b0;

  task automatic ref_step(input int c);
    bit exp_trig;
    bit exp_done;
    int d;
    int l;
    exp_trig = 1'b0;
    exp_done = 1'b0;
    if (!s_rst) begin
      mph      = M_IDLE;
      err_exp  = 1'b0;
      busy_on  = -1;
      busy_off = -1;
      trig_at  = -1;
      done_at  = -1;
      check("rst_trigger", spi_trigger_out, 0);
      check("rst_data", spi_data_out, 0);
      check("rst_addr", bram_addr_out, 0);
      check("rst_hcount", hcount_out, 0);
      check("rst_vcount", vcount_out, 0);
      check("rst_frame_busy", frame_busy_out, 0);
      check("rst_done", frame_done_out, 0);
      check("rst_error", error_out, 0);
      return;
    end
    if (frame_done_out) dut_done_cnt++;
    case (mph)
      M_IDLE: begin
        if (s_start) begin
          mph     = M_PEND;
          idx     = 0;
          trig_at = c + LAT + 1;
          check("accept_addr", bram_addr_out, 0);
        end
      end
      M_PEND: begin
        if (c == trig_at) begin
          exp_trig = 1'b1;
          trig_count++;
          check("trig_data", spi_data_out, mem[idx]);
          check("trig_hcount", hcount_out, idx % H);
          check("trig_vcount", vcount_out, idx / H);
          check("trig_addr", bram_addr_out, idx);
          if (bfm_noack) begin
            mph    = M_NOACK;
            err_at = c + ACK;
          end else begin
            d        = int'($urandom_range(0, 3));
            l        = int'($urandom_range(1, 6));
            busy_on  = c + d;
            busy_off = c + d + l;
            fall_at  = c + d + l + 1;
            mph      = M_XFER;
          end
        end
      end
      M_XFER: begin
        if (c == fall_at) begin
          if (idx == NPIX - 1) begin
            mph     = M_DONE;
            done_at = c + 1;
          end else begin
            idx++;
            mph      = M_GAP;
            gap_from = c;
          end
        end
      end
      M_NOACK: begin
        if (c == err_at) begin
          err_exp  = 1'b1;
          err_seen = 1'b1;
          mph      = M_IDLE;
        end
      end
      M_DONE: begin
        if (c == done_at) begin
          exp_done = 1'b1;
          frames_done++;
          check("done_addr", bram_addr_out, 0);
          check("done_hcount", hcount_out, 0);
          check("done_vcount", vcount_out, 0);
          mph = M_IDLE;
        end
      end
      default: ;
    endcase
    // Next fetch begins once the gap has elapsed and pause is low.
    if (mph == M_GAP && c >= gap_from + GAP && !s_pause) begin
      mph     = M_PEND;
      trig_at = c + LAT + 1;
    end
    check("trigger", spi_trigger_out, exp_trig);
    check("frame_done", frame_done_out, exp_done);
    check("error", error_out, err_exp);
    check("frame_busy", frame_busy_out, mph != M_IDLE);
  endtask

  // Monitor plus BRAM and sender models, all on the falling edge.
  // NOTE: inputs are driven with blocking assignments on the falling edge,
  // half a cycle clear of the edge where the DUT samples them.
  initial forever begin
    @(negedge clk);
    if (cyc > 0) ref_step(cyc);
    spi_busy_in = (cyc >= busy_on) && (cyc < busy_off);
    for (int i = LAT; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = int'(bram_addr_out);
    bram_data_in = (hist[LAT] < NPIX) ? mem[hist[LAT]] : 8'h00;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    frame_start_in = 1'b1;
    @(negedge clk);
    frame_start_in = 1'b0;
  endtask

  task automatic wait_trig(input int target, input int budget);
    int n = 0;
    while (trig_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_trigger", trig_count >= target, 1);
  endtask

  task automatic wait_frames(input int target, input int budget);
    int n = 0;
    while (frames_done < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("wait_frame", frames_done >= target, 1);
  endtask

  initial begin
    int base;
    int n;
    for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    for (int i = 0; i <= LAT; i++) hist[i] = 0;

    // Reset and release.
    tick(3);
    rst_in = 1'b1;
    tick(3);

    // Full frame with random sender timing.
    pulse_start();
    wait_frames(1, 4000);

    // Start requests during a frame are ignored.
    base = trig_count;
    pulse_start();
    wait_trig(base + 3, 500);
    pulse_start();
    wait_trig(base + 12, 1000);
    pulse_start();
    wait_frames(2, 4000);
    tick(60);
    check("done_pulses_single", dut_done_cnt, 2);

    // Long pause during a transfer, then random pause activity.
    base = trig_count;
    pulse_start();
    wait_trig(base + 5, 500);
    pause_in = 1'b1;
    tick(50);
    pause_in = 1'b0;
    n = 0;
    while (frames_done < 3 && n < 6000) begin
      @(negedge clk);
      pause_in = ($urandom_range(0, 7) == 0);
      n++;
    end
    pause_in = 1'b0;
    wait_frames(3, 4000);

    // One-cycle reset mid-frame, then a clean restart.
    base = trig_count;
    pulse_start();
    wait_trig(base + 10, 1000);
    @(negedge clk);
    rst_in = 1'b0;
    @(negedge clk);
    rst_in = 1'b1;
    tick(5);
    pulse_start();
    wait_frames(4, 4000);
    tick(20);
    check("done_pulses_after_reset", dut_done_cnt, 4);

    // Sender never acknowledges: sticky error, no further triggers.
    bfm_noack = 1'b1;
    base = trig_count;
    pulse_start();
    n = 0;
    while (!err_seen && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("wait_error", err_seen, 1);
    tick(100);
    check("no_trigger_after_error", trig_count, base + 1);
    bfm_noack = 1'b0;

    // Error stays set through a following good frame; only reset clears it.
    pulse_start();
    wait_frames(5, 4000);
    tick(5);
    rst_in = 1'b0;
    tick(2);
    rst_in = 1'b1;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule
